// File: rtl/line_timing_meter.sv
// Measures incoming video timing (line period, active pixels, lines per frame) and
// drives the line-buffer wrap value once the line period has been stable long enough.

module line_timing_meter #(
    parameter int W             = 12,
    parameter int DEFAULT_WIDTH = 1599,
    parameter int MIN_PERIOD    = 64,
    parameter int LOCK_LINES    = 4,
    parameter int UNLOCK_LINES  = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rx_dv_i,
    input  logic         rx_hs_i,
    input  logic         rx_vs_i,
    output logic [W-1:0] pic_width_o,
    output logic         locked_o,
    output logic [W-1:0] active_width_o,
    output logic [W-1:0] frame_lines_o,
    output logic         line_stb_o,
    output logic         err_stb_o
);

    localparam int MW = $clog2(LOCK_LINES + 1);
    localparam int UW = $clog2(UNLOCK_LINES + 1);

    localparam logic [W-1:0]  CNT_MAX    = {W{1'b1}};
    localparam logic [W-1:0]  CNT_PRE    = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0]  MIN_P      = W'(MIN_PERIOD);
    localparam logic [W-1:0]  DEF_WIDTH  = W'(DEFAULT_WIDTH);
    localparam logic [MW-1:0] LOCK_CNT   = MW'(LOCK_LINES);
    localparam logic [UW-1:0] UNLOCK_CNT = UW'(UNLOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic          hsDly_q, hsDly_d;
    logic          vsDly_q, vsDly_d;
    logic [W-1:0]  periodCnt_q, periodCnt_d;
    logic [W-1:0]  activeCnt_q, activeCnt_d;
    logic [W-1:0]  lineCnt_q, lineCnt_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [MW-1:0] match_q, match_d;
    logic [UW-1:0] miss_q, miss_d;
    logic [W-1:0]  picWidth_q, picWidth_d;
    logic          locked_q, locked_d;
    logic [W-1:0]  activeWidth_q, activeWidth_d;
    logic [W-1:0]  frameLines_q, frameLines_d;
    logic          lineStb_q, lineStb_d;
    logic          errStb_q, errStb_d;

    logic          hsRise;
    logic          vsRise;
    logic          timeout;
    logic [MW-1:0] matchInc;
    logic [UW-1:0] missInc;

    assign hsRise   = rx_hs_i & ~hsDly_q;
    assign vsRise   = rx_vs_i & ~vsDly_q;
    // Fires only on the step into saturation, so a long gap reports a single error.
    assign timeout  = ~hsRise & (periodCnt_q == CNT_PRE);
    assign matchInc = match_q + MW'(1);
    assign missInc  = miss_q + UW'(1);

    always_comb begin : counter_next
        hsDly_d = rx_hs_i;
        vsDly_d = rx_vs_i;

        if (hsRise) begin
            periodCnt_d = W'(1);
        end else if (periodCnt_q == CNT_MAX) begin
            periodCnt_d = CNT_MAX;
        end else begin
            periodCnt_d = periodCnt_q + W'(1);
        end

        activeCnt_d = hsRise ? W'(rx_dv_i) : activeCnt_q + W'(rx_dv_i);

        // hs in the vs cycle opens the new frame, so it seeds rather than adds.
        lineCnt_d    = vsRise ? W'(hsRise) : lineCnt_q + W'(hsRise);
        frameLines_d = vsRise ? lineCnt_q : frameLines_q;
    end

    always_comb begin : fsm_next
        state_d       = state_q;
        cand_d        = cand_q;
        match_d       = match_q;
        miss_d        = miss_q;
        picWidth_d    = picWidth_q;
        locked_d      = locked_q;
        activeWidth_d = activeWidth_q;
        lineStb_d     = 1'b0;
        errStb_d      = 1'b0;

        if (timeout) begin
            state_d  = SEARCH;
            locked_d = 1'b0;
            errStb_d = 1'b1;
        end else if (hsRise) begin
            case (state_q)
                SEARCH: begin
                    state_d = TRACK;
                    cand_d  = '0;
                    match_d = '0;
                    miss_d  = '0;
                end
                TRACK: begin
                    lineStb_d     = 1'b1;
                    activeWidth_d = activeCnt_q;
                    if (periodCnt_q < MIN_P) begin
                        errStb_d = 1'b1;
                        match_d  = '0;
                    end else if (periodCnt_q == cand_q) begin
                        match_d = matchInc;
                        if (matchInc == LOCK_CNT) begin
                            state_d    = LOCKED;
                            picWidth_d = periodCnt_q - W'(1);
                            locked_d   = 1'b1;
                            miss_d     = '0;
                        end
                    end else begin
                        cand_d   = periodCnt_q;
                        match_d  = MW'(1);
                        errStb_d = 1'b1;
                    end
                end
                LOCKED: begin
                    lineStb_d     = 1'b1;
                    activeWidth_d = activeCnt_q;
                    if (periodCnt_q == cand_q) begin
                        miss_d = '0;
                    end else begin
                        errStb_d = 1'b1;
                        miss_d   = missInc;
                        // pic_width is deliberately left at the last locked value.
                        if (missInc == UNLOCK_CNT) begin
                            state_d  = TRACK;
                            cand_d   = periodCnt_q;
                            match_d  = MW'(1);
                            miss_d   = '0;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SEARCH;
            hsDly_q       <= 1'b0;
            vsDly_q       <= 1'b0;
            periodCnt_q   <= '0;
            activeCnt_q   <= '0;
            lineCnt_q     <= '0;
            cand_q        <= '0;
            match_q       <= '0;
            miss_q        <= '0;
            picWidth_q    <= DEF_WIDTH;
            locked_q      <= 1'b0;
            activeWidth_q <= '0;
            frameLines_q  <= '0;
            lineStb_q     <= 1'b0;
            errStb_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hsDly_q       <= hsDly_d;
            vsDly_q       <= vsDly_d;
            periodCnt_q   <= periodCnt_d;
            activeCnt_q   <= activeCnt_d;
            lineCnt_q     <= lineCnt_d;
            cand_q        <= cand_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            picWidth_q    <= picWidth_d;
            locked_q      <= locked_d;
            activeWidth_q <= activeWidth_d;
            frameLines_q  <= frameLines_d;
            lineStb_q     <= lineStb_d;
            errStb_q      <= errStb_d;
        end
    end

    assign pic_width_o    = picWidth_q;
    assign locked_o       = locked_q;
    assign active_width_o = activeWidth_q;
    assign frame_lines_o  = frameLines_q;
    assign line_stb_o     = lineStb_q;
    assign err_stb_o      = errStb_q;

endmodule

// File: tb/tb_line_timing_meter.sv
// Bench for line_timing_meter: a timestamp-based reference model checked every cycle,
// plus directed literal expectations for lock, slip, relock, timeout, frame and reset cases.

module tb_line_timing_meter;

    localparam int W    = 12;
    localparam int MAXC = 4095;
    localparam int HSW  = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_dv;
    logic         rx_hs;
    logic         rx_vs;
    logic [W-1:0] pic_width;
    logic         locked;
    logic [W-1:0] active_width;
    logic [W-1:0] frame_lines;
    logic         line_stb;
    logic         err_stb;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    line_timing_meter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_dv_i        (rx_dv),
        .rx_hs_i        (rx_hs),
        .rx_vs_i        (rx_vs),
        .pic_width_o    (pic_width),
        .locked_o       (locked),
        .active_width_o (active_width),
        .frame_lines_o  (frame_lines),
        .line_stb_o     (line_stb),
        .err_stb_o      (err_stb)
    );

    // Reference model: line period is the distance between hs rise timestamps.
    int cyc = 0;
    bit mValid = 0;
    int lastRise, dvCnt, lnCnt;
    int mState;                  // 0 searching, 1 tracking, 2 locked
    int mCand, mMatch, mMiss;
    int ePic, eLocked, eAct, eFrame, eLine, eErr;
    bit hsPrev, vsPrev;
    int errSeen = 0;
    int lineSeen = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelStep();
        int elapsed;
        bit hsR, vsR;
        if (rst) begin
            mValid   = 1;
            lastRise = cyc + 1;
            dvCnt    = 0;
            lnCnt    = 0;
            mState   = 0;
            mCand    = 0;
            mMatch   = 0;
            mMiss    = 0;
            ePic     = 1599;
            eLocked  = 0;
            eAct     = 0;
            eFrame   = 0;
            eLine    = 0;
            eErr     = 0;
            hsPrev   = 0;
            vsPrev   = 0;
        end else if (mValid) begin
            eLine = 0;
            eErr  = 0;
            hsR = rx_hs && !hsPrev;
            vsR = rx_vs && !vsPrev;
            elapsed = cyc - lastRise;
            if (elapsed > MAXC) elapsed = MAXC;
            if (vsR) begin
                eFrame = lnCnt % 4096;
                lnCnt  = int'(hsR);
            end else begin
                lnCnt += int'(hsR);
            end
            if (hsR) begin
                if (mState == 0) begin
                    mState = 1;
                    mCand  = 0;
                    mMatch = 0;
                    mMiss  = 0;
                end else begin
                    eLine = 1;
                    eAct  = dvCnt % 4096;
                    if (mState == 1) begin
                        if (elapsed < 64) begin
                            eErr = 1;
                            mMatch = 0;
                        end else if (elapsed == mCand) begin
                            mMatch++;
                            if (mMatch == 4) begin
                                mState  = 2;
                                ePic    = elapsed - 1;
                                eLocked = 1;
                                mMiss   = 0;
                            end
                        end else begin
                            mCand  = elapsed;
                            mMatch = 1;
                            eErr   = 1;
                        end
                    end else begin
                        if (elapsed == mCand) begin
                            mMiss = 0;
                        end else begin
                            eErr = 1;
                            mMiss++;
                            if (mMiss == 3) begin
                                mState  = 1;
                                mCand   = elapsed;
                                mMatch  = 1;
                                mMiss   = 0;
                                eLocked = 0;
                            end
                        end
                    end
                end
                lastRise = cyc;
                dvCnt    = int'(rx_dv);
            end else begin
                dvCnt += int'(rx_dv);
                if (cyc - lastRise == MAXC - 1) begin
                    mState  = 0;
                    eLocked = 0;
                    eErr    = 1;
                end
            end
            hsPrev = rx_hs;
            vsPrev = rx_vs;
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (mValid) begin
            checkOutput("pic_width",    32'(pic_width),    ePic);
            checkOutput("locked",       32'(locked),       eLocked);
            checkOutput("active_width", 32'(active_width), eAct);
            checkOutput("frame_lines",  32'(frame_lines),  eFrame);
            checkOutput("line_stb",     32'(line_stb),     eLine);
            checkOutput("err_stb",      32'(err_stb),      eErr);
            if (err_stb === 1'b1) errSeen++;
            if (line_stb === 1'b1) lineSeen++;
        end
    end

    task automatic applyStimulus(input logic hs, input logic vs, input logic dv);
        rx_hs = hs;
        rx_vs = vs;
        rx_dv = dv;
        @(negedge clk);
    endtask

    task automatic runLine(input int period, input int dvStart, input int dvLen,
                           input bit withVs, input int from);
        for (int c = from; c < period; c++) begin
            applyStimulus(c < HSW, withVs && (c < HSW), (c >= dvStart) && (c < dvStart + dvLen));
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0, l0, per, cnt;
        rst   = 1'b1;
        rx_hs = 1'b0;
        rx_vs = 1'b0;
        rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_pic_width", 32'(pic_width), 1599);
        checkOutput("reset_locked",    32'(locked),    0);
        rst = 1'b0;

        // Lock at 1650 clocks: locked appears right after the fifth hs rise.
        for (int i = 0; i < 4; i++) runLine(1650, 20, 1280, 0, 0);
        checkOutput("s1_unlocked_before_5th", 32'(locked), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s1_locked",       32'(locked),       1);
        checkOutput("s1_pic_width",    32'(pic_width),    1649);
        checkOutput("s1_active_width", 32'(active_width), 1280);
        runLine(1650, 20, 1280, 0, 1);

        // One short line while locked.
        e0 = errSeen;
        runLine(1649, 20, 1280, 0, 0);
        for (int i = 0; i < 3; i++) runLine(1650, 20, 1280, 0, 0);
        checkOutput("s2_single_err", 32'(errSeen - e0), 1);
        checkOutput("s2_locked",     32'(locked),       1);
        checkOutput("s2_pic_width",  32'(pic_width),    1649);

        // Switch to 2200-clock lines: unlock on third mismatch, relock later.
        for (int i = 0; i < 3; i++) runLine(2200, 20, 1920, 0, 0);
        checkOutput("s3_locked_two_miss", 32'(locked), 1);
        runLine(2200, 20, 1920, 0, 0);
        checkOutput("s3_unlocked", 32'(locked), 0);
        checkOutput("s3_pic_kept", 32'(pic_width), 1649);
        for (int i = 0; i < 2; i++) runLine(2200, 20, 1920, 0, 0);
        checkOutput("s3_still_unlocked", 32'(locked), 0);
        runLine(2200, 20, 1920, 0, 0);
        checkOutput("s3_relocked",  32'(locked),    1);
        checkOutput("s3_pic_width", 32'(pic_width), 2199);

        // hs stuck low beyond the counter range.
        e0 = errSeen;
        repeat (2000) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s4_timeout_err", 32'(errSeen - e0), 1);
        checkOutput("s4_unlocked",    32'(locked),       0);
        l0 = lineSeen;
        e0 = errSeen;
        runLine(30, 10, 10, 0, 0);
        checkOutput("s4_search_no_line_stb", 32'(lineSeen - l0), 0);
        runLine(30, 10, 10, 0, 0);
        checkOutput("s4_glitch_err",    32'(errSeen - e0), 1);
        checkOutput("s4_glitch_nolock", 32'(locked),       0);

        // Random line periods with frequent repeats, random dv windows and occasional vsync.
        per = 120;
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 9) < 3) per = $urandom_range(20, 200);
            cnt = $urandom_range(0, per);
            runLine(per, $urandom_range(0, per - 1), cnt, $urandom_range(0, 9) == 0, 0);
        end

        // Frame height: 750 lines, then a 37-line frame.
        runLine(64, 10, $urandom_range(0, 50), 1, 0);
        for (int i = 0; i < 749; i++) runLine(64, 10, $urandom_range(0, 50), 0, 0);
        runLine(64, 10, $urandom_range(0, 50), 1, 0);
        checkOutput("s5_frame_750", 32'(frame_lines), 750);
        checkOutput("s5_locked",    32'(locked),      1);
        checkOutput("s5_pic_width", 32'(pic_width),   63);
        for (int i = 0; i < 36; i++) runLine(64, 10, $urandom_range(0, 50), 0, 0);
        runLine(64, 10, $urandom_range(0, 50), 1, 0);
        checkOutput("s5_frame_37", 32'(frame_lines), 37);

        // One-cycle reset mid-line while locked.
        runLine(64, 10, 20, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("s6_pic_width",    32'(pic_width),    1599);
        checkOutput("s6_locked",       32'(locked),       0);
        checkOutput("s6_active_width", 32'(active_width), 0);
        checkOutput("s6_frame_lines",  32'(frame_lines),  0);
        for (int i = 0; i < 6; i++) runLine(100, 15, $urandom_range(0, 80), 0, 0);
        checkOutput("s6_relocked",  32'(locked),    1);
        checkOutput("s6_pic_width_relock", 32'(pic_width), 99);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
